// File: rtl/mem_alu_unit.sv
// Memory-and-execute slice: MDR, word-addressed RAM fed from the MDR, and a
// combinational ALU producing a 64-bit HI/LO result for the Z register.
module mem_alu_unit #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              Read,
  input  logic              Write,
  input  logic              MDR_enable,
  input  logic [DATA_W-1:0] bus_in,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] y_in,
  input  logic [4:0]        opcode,
  input  logic              IncPC,
  input  logic              branch_flag,
  output logic [DATA_W-1:0] mdr_out,
  output logic [DATA_W-1:0] ram_out,
  output logic [DATA_W-1:0] c_hi,
  output logic [DATA_W-1:0] c_lo
);

  localparam logic signed [DATA_W-1:0] INT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] mdr_d, mdr_q;

  // ---- Memory stage: MDR and asynchronous-read RAM ----
  assign ram_out = mem[addr];
  assign mdr_out = mdr_q;

  always_comb begin
    mdr_d = mdr_q;
    if (MDR_enable) mdr_d = Read ? ram_out : bus_in;
  end

  always_ff @(posedge clk) begin
    if (!clr) mdr_q <= '0;
    else      mdr_q <= mdr_d;
  end

  // The RAM is written from the pre-edge MDR and ignores clr entirely.
  always_ff @(posedge clk) begin
    if (Write) mem[addr] <= mdr_q;
  end

  // ---- Execute stage: combinational ALU ----
  logic signed [DATA_W-1:0]   a_s, b_s;
  logic signed [2*DATA_W-1:0] a_w, b_w, prod;
  logic [4:0]                 shamt;
  logic [5:0]                 shamt_inv;
  logic [DATA_W-1:0]          alu_hi, alu_lo;

  assign a_s       = y_in;
  assign b_s       = bus_in;
  assign a_w       = a_s;
  assign b_w       = b_s;
  assign prod      = a_w * b_w;
  assign shamt     = bus_in[4:0];
  assign shamt_inv = 6'd32 - {1'b0, shamt};

  always_comb begin
    alu_hi = '0;
    alu_lo = '0;
    if (IncPC) begin
      alu_lo = bus_in + DATA_W'(1);
    end else begin
      case (opcode)
        5'b00000, 5'b00001, 5'b00010, 5'b01100,
        5'b00011: alu_lo = y_in + bus_in;
        5'b00100: alu_lo = y_in - bus_in;
        5'b00101, 5'b01101: alu_lo = y_in & bus_in;
        5'b00110, 5'b01110: alu_lo = y_in | bus_in;
        5'b00111: alu_lo = y_in >> shamt;
        5'b01000: alu_lo = a_s >>> shamt;
        5'b01001: alu_lo = y_in << shamt;
        5'b01010: alu_lo = (y_in >> shamt) | (y_in << shamt_inv);
        5'b01011: alu_lo = (y_in << shamt) | (y_in >> shamt_inv);
        5'b01111: {alu_hi, alu_lo} = prod;
        5'b10000: begin
          if (bus_in == '0) begin
            alu_lo = '1;
            alu_hi = y_in;
          end else if (a_s == INT_MIN && b_s == '1) begin
            // Quotient overflows; wrap it and avoid a trapping host division.
            alu_lo = INT_MIN;
            alu_hi = '0;
          end else begin
            alu_lo = a_s / b_s;
            alu_hi = a_s % b_s;
          end
        end
        5'b10001: alu_lo = -bus_in;
        5'b10010: alu_lo = ~bus_in;
        5'b10011: alu_lo = branch_flag ? (y_in + bus_in) : y_in;
        5'b10100, 5'b10101, 5'b10110, 5'b10111,
        5'b11000, 5'b11001, 5'b11010, 5'b11011: alu_lo = bus_in;
        default: alu_lo = '0;
      endcase
    end
  end

  assign c_hi = alu_hi;
  assign c_lo = alu_lo;

endmodule

// File: tb/tb_mem_alu_unit.sv
// Randomised self-checking bench for mem_alu_unit against a behavioural
// model of the MDR/RAM and the ALU opcode table.
module tb_mem_alu_unit;

  logic        clk = 1'b0;
  logic        clr, Read, Write, MDR_enable, IncPC, branch_flag;
  logic [31:0] bus_in, y_in;
  logic [8:0]  addr;
  logic [4:0]  opcode;
  logic [31:0] mdr_out, ram_out, c_hi, c_lo;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_mdr;
  logic [31:0] m_mem [int];

  typedef struct {
    string       nm;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic        inc, flag;
    logic [31:0] hi, lo;
  } vec_t;

  mem_alu_unit dut (
    .clk(clk), .clr(clr), .Read(Read), .Write(Write), .MDR_enable(MDR_enable),
    .bus_in(bus_in), .addr(addr), .y_in(y_in), .opcode(opcode), .IncPC(IncPC),
    .branch_flag(branch_flag), .mdr_out(mdr_out), .ram_out(ram_out),
    .c_hi(c_hi), .c_lo(c_lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference ALU written straight from the opcode table with plain arithmetic.
  function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic inc,
                                          input logic flag);
    logic [31:0] hi, lo;
    longint sa, sb, p;
    int n;
    hi = 0; lo = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    n  = int'(b % 32);
    if (inc) lo = b + 1;
    else case (op) inside
      5'd0, 5'd1, 5'd2, 5'd3, 5'd12: lo = a + b;
      5'd4:  lo = a - b;
      5'd5, 5'd13: lo = a & b;
      5'd6, 5'd14: lo = a | b;
      5'd7:  begin lo = a; repeat (n) lo = lo / 2; end
      5'd8:  begin lo = a; repeat (n) lo = {lo[31], lo[31:1]}; end
      5'd9:  begin lo = a; repeat (n) lo = lo * 2; end
      5'd10: begin lo = a; repeat (n) lo = {lo[0], lo[31:1]}; end
      5'd11: begin lo = a; repeat (n) lo = lo * 2 + {31'd0, lo[31]}; end
      5'd15: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      5'd16: begin
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin p = sa / sb; lo = p[31:0]; p = sa % sb; hi = p[31:0]; end
      end
      5'd17: lo = 32'd0 - b;
      5'd18: lo = ~b;
      5'd19: lo = flag ? a + b : a;
      [5'd20:5'd27]: lo = b;
      default: lo = 0;
    endcase
    return {hi, lo};
  endfunction

  task automatic test_reset();
    clr = 1'b0; MDR_enable = 1'b1; Read = 1'b0; Write = 1'b0;
    bus_in = 32'h5555_AAAA; addr = 9'h000;
    tick(); tick();
    m_mdr = 32'h0;
    n_checks++;
    if (mdr_out !== 32'h0) begin
      n_fail++; $display("FAIL reset_mdr: got %h want %h", mdr_out, 32'h0);
    end
    clr = 1'b1; MDR_enable = 1'b0;
  endtask

  task automatic test_mdr();
    MDR_enable = 1'b1; Read = 1'b0; bus_in = 32'h1234_5678;
    tick();
    n_checks++;
    if (mdr_out !== 32'h1234_5678) begin
      n_fail++; $display("FAIL mdr_load: got %h want %h", mdr_out, 32'h1234_5678);
    end
    MDR_enable = 1'b0; bus_in = 32'hFFFF_0000;
    tick(); tick();
    n_checks++;
    if (mdr_out !== 32'h1234_5678) begin
      n_fail++; $display("FAIL mdr_hold: got %h want %h", mdr_out, 32'h1234_5678);
    end
    m_mdr = 32'h1234_5678;
  endtask

  task automatic test_store_load();
    logic [8:0]  adrs [2] = '{9'h01F, 9'h1FF};
    logic [31:0] vals [2] = '{32'hDEAD_BEEF, 32'hCAFE_F00D};
    for (int i = 0; i < 2; i++) begin
      Read = 1'b0; Write = 1'b0; MDR_enable = 1'b1; bus_in = vals[i];
      tick();
      MDR_enable = 1'b0; addr = adrs[i]; Write = 1'b1;
      tick();
      Write = 1'b0;
      m_mem[int'(adrs[i])] = vals[i];
      n_checks++;
      if (ram_out !== vals[i]) begin
        n_fail++; $display("FAIL store_%0d: got %h want %h", i, ram_out, vals[i]);
      end
      MDR_enable = 1'b1; bus_in = 32'h0;
      tick();
      Read = 1'b1;
      tick();
      MDR_enable = 1'b0; Read = 1'b0;
      m_mdr = vals[i];
      n_checks++;
      if (mdr_out !== vals[i]) begin
        n_fail++; $display("FAIL load_%0d: got %h want %h", i, mdr_out, vals[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Read+Write together: MDR takes the old word, RAM takes the old MDR.
    logic [31:0] old_word;
    old_word = m_mem[int'(9'h01F)];
    MDR_enable = 1'b1; Read = 1'b0; bus_in = 32'h0BAD_F00D;
    tick();
    addr = 9'h01F; Read = 1'b1; Write = 1'b1;
    tick();
    Write = 1'b0; MDR_enable = 1'b0; Read = 1'b0;
    n_checks++;
    if (mdr_out !== old_word || ram_out !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL rd_wr_same_edge: got mdr=%h ram=%h want mdr=%h ram=%h",
                         mdr_out, ram_out, old_word, 32'h0BAD_F00D);
    end
    // A write on a reset edge still lands, with the pre-reset MDR value.
    addr = 9'h100; clr = 1'b0; Write = 1'b1;
    tick();
    clr = 1'b1; Write = 1'b0;
    n_checks++;
    if (ram_out !== old_word || mdr_out !== 32'h0) begin
      n_fail++; $display("FAIL write_during_reset: got mdr=%h ram=%h want mdr=%h ram=%h",
                         mdr_out, ram_out, 32'h0, old_word);
    end
    m_mem[int'(9'h01F)] = 32'h0BAD_F00D;
    m_mem[int'(9'h100)] = old_word;
    m_mdr = 32'h0;
  endtask

  task automatic test_mem_random();
    logic [8:0]  pool [4] = '{9'h000, 9'h01F, 9'h100, 9'h1FF};
    logic [31:0] old_word;
    for (int i = 0; i < 4; i++) begin
      MDR_enable = 1'b1; Read = 1'b0; Write = 1'b0; bus_in = $urandom;
      tick();
      m_mdr = bus_in;
      MDR_enable = 1'b0; addr = pool[i]; Write = 1'b1;
      tick();
      Write = 1'b0;
      m_mem[int'(pool[i])] = m_mdr;
    end
    for (int i = 0; i < 200; i++) begin
      addr = pool[$urandom_range(0, 3)];
      Read = 1'($urandom); Write = 1'($urandom); MDR_enable = 1'($urandom);
      bus_in = $urandom;
      old_word = m_mem[int'(addr)];
      if (Write) m_mem[int'(addr)] = m_mdr;
      if (MDR_enable) m_mdr = Read ? old_word : bus_in;
      tick();
      n_checks++;
      if (mdr_out !== m_mdr || ram_out !== m_mem[int'(addr)]) begin
        n_fail++; $display("FAIL mem_rand_%0d: got mdr=%h ram=%h want mdr=%h ram=%h",
                           i, mdr_out, ram_out, m_mdr, m_mem[int'(addr)]);
      end
    end
    Read = 1'b0; Write = 1'b0; MDR_enable = 1'b0;
  endtask

  task automatic test_alu_directed();
    vec_t vq[$];
    vq.push_back('{"add",    5'd3,  32'd7, 32'd5, 1'b0, 1'b0, 32'h0, 32'd12});
    vq.push_back('{"sub",    5'd4,  32'd7, 32'd5, 1'b0, 1'b0, 32'h0, 32'd2});
    vq.push_back('{"and",    5'd5,  32'd7, 32'd5, 1'b0, 1'b0, 32'h0, 32'd5});
    vq.push_back('{"or",     5'd6,  32'd7, 32'd5, 1'b0, 1'b0, 32'h0, 32'd7});
    vq.push_back('{"sub_uf", 5'd4,  32'd0, 32'd1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF});
    vq.push_back('{"ld",     5'd0,  32'd1, 32'd2, 1'b0, 1'b0, 32'h0, 32'd3});
    vq.push_back('{"shr",    5'd7,  32'h8000_0001, 32'd1, 1'b0, 1'b0, 32'h0, 32'h4000_0000});
    vq.push_back('{"shra",   5'd8,  32'h8000_0001, 32'd1, 1'b0, 1'b0, 32'h0, 32'hC000_0000});
    vq.push_back('{"shl",    5'd9,  32'h8000_0001, 32'd1, 1'b0, 1'b0, 32'h0, 32'h0000_0002});
    vq.push_back('{"ror",    5'd10, 32'h8000_0001, 32'd1, 1'b0, 1'b0, 32'h0, 32'hC000_0000});
    vq.push_back('{"rol",    5'd11, 32'h8000_0001, 32'd1, 1'b0, 1'b0, 32'h0, 32'h0000_0003});
    vq.push_back('{"shr_21", 5'd7,  32'h8000_0001, 32'h21, 1'b0, 1'b0, 32'h0, 32'h4000_0000});
    vq.push_back('{"rol_21", 5'd11, 32'h8000_0001, 32'h21, 1'b0, 1'b0, 32'h0, 32'h0000_0003});
    vq.push_back('{"mul",    5'd15, 32'hFFFF_FFFD, 32'd4, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF4});
    vq.push_back('{"div",    5'd16, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vq.push_back('{"div0",   5'd16, 32'd9, 32'd0, 1'b0, 1'b0, 32'd9, 32'hFFFF_FFFF});
    vq.push_back('{"incpc",  5'd15, 32'd99, 32'h10, 1'b1, 1'b0, 32'h0, 32'h11});
    vq.push_back('{"incdiv", 5'd16, 32'd5, 32'h10, 1'b1, 1'b1, 32'h0, 32'h11});
    vq.push_back('{"br_t",   5'd19, 32'h20, 32'h4, 1'b0, 1'b1, 32'h0, 32'h24});
    vq.push_back('{"br_f",   5'd19, 32'h20, 32'h4, 1'b0, 1'b0, 32'h0, 32'h20});
    vq.push_back('{"neg",    5'd17, 32'd3, 32'd1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF});
    vq.push_back('{"not",    5'd18, 32'd3, 32'd0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF});
    vq.push_back('{"mfhi",   5'd24, 32'd3, 32'hABC, 1'b0, 1'b0, 32'h0, 32'hABC});
    vq.push_back('{"resv",   5'd28, 32'd3, 32'hABC, 1'b0, 1'b0, 32'h0, 32'h0});
    foreach (vq[i]) begin
      opcode = vq[i].op; y_in = vq[i].a; bus_in = vq[i].b;
      IncPC = vq[i].inc; branch_flag = vq[i].flag;
      #1;
      n_checks++;
      if (c_hi !== vq[i].hi || c_lo !== vq[i].lo) begin
        n_fail++; $display("FAIL alu_%s: got %h_%h want %h_%h",
                           vq[i].nm, c_hi, c_lo, vq[i].hi, vq[i].lo);
      end
    end
    IncPC = 1'b0;
  endtask

  task automatic test_alu_random();
    logic [63:0] exp;
    for (int i = 0; i < 400; i++) begin
      opcode = 5'($urandom); y_in = $urandom; bus_in = $urandom;
      if ($urandom_range(0, 3) == 0) bus_in = $urandom_range(0, 40);
      if ($urandom_range(0, 15) == 0) bus_in = 32'h0;
      IncPC = ($urandom_range(0, 7) == 0);
      branch_flag = 1'($urandom);
      exp = ref_alu(opcode, y_in, bus_in, IncPC, branch_flag);
      #1;
      n_checks++;
      if ({c_hi, c_lo} !== exp) begin
        n_fail++; $display("FAIL alu_rand_%0d op=%0d a=%h b=%h: got %h_%h want %h_%h",
                           i, opcode, y_in, bus_in, c_hi, c_lo, exp[63:32], exp[31:0]);
      end
    end
    IncPC = 1'b0;
  endtask

  initial begin
    clr = 1'b1; Read = 1'b0; Write = 1'b0; MDR_enable = 1'b0;
    bus_in = '0; addr = '0; y_in = '0; opcode = '0; IncPC = 1'b0; branch_flag = 1'b0;
    test_reset();
    test_mdr();
    test_store_load();
    test_back_to_back();
    test_mem_random();
    test_alu_directed();
    test_alu_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
